// File: rtl/voter_ballot_collector.sv
// Ballot collector for the 4-voter majority voter: gathers one vote per voter
// within a timeout window, presents the ballot, and latches the verdict until acked.
module voter_ballot_collector #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] vote_valid,
    input  logic [3:0] vote_val,
    output logic [3:0] vote_ack,
    output logic [3:0] ballot,
    output logic       ballot_valid,
    input  logic [2:0] verdict_in,
    output logic [2:0] result,
    output logic       result_valid,
    input  logic       result_ack,
    output logic       timed_out,
    output logic       verdict_err,
    output logic       busy
);

    localparam int unsigned NV = 4;
    localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_EVAL    = 2'd2,
        S_DONE    = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [NV-1:0]     ballot_q, ballot_d;
    logic [NV-1:0]     recv_q, recv_d;
    logic [NV-1:0]     vote_ack_q, vote_ack_d;
    logic [CNT_W-1:0]  timer_q, timer_d;
    logic [2:0]        result_q, result_d;
    logic              result_valid_q, result_valid_d;
    logic              ballot_valid_q, ballot_valid_d;
    logic              timed_out_q, timed_out_d;
    logic              verdict_err_q, verdict_err_d;
    logic              busy_q, busy_d;
    logic [NV-1:0]     accept_c;
    logic              verdict_onehot_c;

    // Only the three legal one-hot verdict codes are accepted from the voter.
    assign verdict_onehot_c = (verdict_in == 3'b100) || (verdict_in == 3'b010) ||
                              (verdict_in == 3'b001);

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            ballot_q       <= '0;
            recv_q         <= '0;
            vote_ack_q     <= '0;
            timer_q        <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            ballot_valid_q <= 1'b0;
            timed_out_q    <= 1'b0;
            verdict_err_q  <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            ballot_q       <= ballot_d;
            recv_q         <= recv_d;
            vote_ack_q     <= vote_ack_d;
            timer_q        <= timer_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            ballot_valid_q <= ballot_valid_d;
            timed_out_q    <= timed_out_d;
            verdict_err_q  <= verdict_err_d;
            busy_q         <= busy_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d        = state_q;
        ballot_d       = ballot_q;
        recv_d         = recv_q;
        vote_ack_d     = '0;
        timer_d        = timer_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        ballot_valid_d = 1'b0;
        timed_out_d    = timed_out_q;
        verdict_err_d  = verdict_err_q;
        accept_c       = '0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d       = S_COLLECT;
                    ballot_d      = '0;
                    recv_d        = '0;
                    timer_d       = '0;
                    timed_out_d   = 1'b0;
                    verdict_err_d = 1'b0;
                end
            end
            S_COLLECT: begin
                // First vote per voter wins; repeats are silently dropped.
                accept_c   = vote_valid & ~recv_q;
                vote_ack_d = accept_c;
                ballot_d   = (ballot_q & ~accept_c) | (vote_val & accept_c);
                recv_d     = recv_q | accept_c;
                timer_d    = timer_q + CNT_W'(1);
                if (recv_d == {NV{1'b1}}) begin
                    state_d        = S_EVAL;
                    ballot_valid_d = 1'b1;
                end else if (timer_q == TIMER_LAST) begin
                    state_d        = S_EVAL;
                    ballot_valid_d = 1'b1;
                    timed_out_d    = 1'b1;
                end
            end
            S_EVAL: begin
                result_d       = verdict_onehot_c ? verdict_in : 3'b000;
                verdict_err_d  = ~verdict_onehot_c;
                result_valid_d = 1'b1;
                state_d        = S_DONE;
            end
            S_DONE: begin
                if (result_ack) begin
                    state_d        = S_IDLE;
                    result_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign vote_ack     = vote_ack_q;
    assign ballot       = ballot_q;
    assign ballot_valid = ballot_valid_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign timed_out    = timed_out_q;
    assign verdict_err  = verdict_err_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_voter_ballot_collector.sv
// Scoreboard bench for voter_ballot_collector: per-session vote schedules are
// turned into expected ballots/verdicts by a rule-level model and checked by a monitor.
module tb_voter_ballot_collector;

    localparam int unsigned TO = 16;
    localparam int unsigned NK = 18;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] vote_valid = '0;
    logic [3:0] vote_val = '0;
    logic [3:0] vote_ack;
    logic [3:0] ballot;
    logic       ballot_valid;
    logic [2:0] verdict_in;
    logic [2:0] result;
    logic       result_valid;
    logic       result_ack = 1'b0;
    logic       timed_out;
    logic       verdict_err;
    logic       busy;
    logic       corrupt = 1'b0;

    voter_ballot_collector #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .vote_valid(vote_valid), .vote_val(vote_val), .vote_ack(vote_ack),
        .ballot(ballot), .ballot_valid(ballot_valid), .verdict_in(verdict_in),
        .result(result), .result_valid(result_valid), .result_ack(result_ack),
        .timed_out(timed_out), .verdict_err(verdict_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2:0] majority(input logic [3:0] b);
        int n = 0;
        for (int i = 0; i < 4; i++) n += int'(b[i]);
        if (n < 2) return 3'b100;
        if (n == 2) return 3'b010;
        return 3'b001;
    endfunction

    // Stand-in for the combinational voter, with an optional corrupt verdict.
    always_comb verdict_in = corrupt ? 3'b011 : majority(ballot);

    typedef struct {
        logic [2:0]  res;
        logic [3:0]  bal;
        logic        to;
        logic        err;
        logic [3:0]  acks;
        int unsigned e0;
        int unsigned lat;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    logic [3:0] sv[NK];
    logic [3:0] sl[NK];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Rule-level model: first presentation per voter inside the window counts.
    function automatic exp_t model(input logic cor);
        exp_t e;
        logic [3:0] recv = '0;
        logic [3:0] bal = '0;
        int kc = TO - 1;
        logic to = 1'b1;
        for (int k = 0; k < TO; k++) begin
            for (int i = 0; i < 4; i++)
                if (sv[k][i] && !recv[i]) begin
                    recv[i] = 1'b1;
                    bal[i]  = sl[k][i];
                end
            if (recv == 4'hF) begin
                kc = k;
                to = 1'b0;
                break;
            end
        end
        e.res  = cor ? 3'b000 : majority(bal);
        e.bal  = bal;
        e.to   = to;
        e.err  = cor;
        e.acks = recv;
        e.e0   = 0;
        e.lat  = kc + 2;
        return e;
    endfunction

    // Monitor: checks each new result against the scoreboard and ack pulse counts.
    logic        prev_rv = 1'b0;
    logic        prev_bv = 1'b0;
    logic [2:0]  held_res = '0;
    logic [3:0]  exp_acks = '0;
    int          ack_cnt[4];

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_rv = 1'b0;
            prev_bv = 1'b0;
            for (int i = 0; i < 4; i++) ack_cnt[i] = 0;
        end else begin
            for (int i = 0; i < 4; i++) if (vote_ack[i]) ack_cnt[i]++;
            if (result_valid && !prev_rv) begin
                if (sb.size() == 0) begin
                    chk("scoreboard_underflow", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result", 32'(result), 32'(e.res));
                    chk("ballot", 32'(ballot), 32'(e.bal));
                    chk("timed_out", 32'(timed_out), 32'(e.to));
                    chk("verdict_err", 32'(verdict_err), 32'(e.err));
                    chk("latency", cyc - e.e0, e.lat);
                    chk("ballot_valid_prev", 32'(prev_bv), 32'd1);
                    chk("ballot_valid_now", 32'(ballot_valid), 32'd0);
                    held_res = result;
                    exp_acks = e.acks;
                end
            end else if (result_valid) begin
                chk("result_held", 32'(result), 32'(held_res));
            end
            if (!result_valid && prev_rv) begin
                for (int i = 0; i < 4; i++) begin
                    chk($sformatf("ack_count_%0d", i), 32'(ack_cnt[i]), 32'(exp_acks[i]));
                    ack_cnt[i] = 0;
                end
            end
            prev_rv = result_valid;
            prev_bv = ballot_valid;
        end
    end

    task automatic clear_sched();
        for (int k = 0; k < NK; k++) begin
            sv[k] = '0;
            sl[k] = '0;
        end
    endtask

    task automatic put(input int k, input int i, input logic v);
        sv[k][i] = 1'b1;
        sl[k][i] = v;
    endtask

    task automatic gen_random(input int mode);
        clear_sched();
        case (mode)
            0: for (int i = 0; i < 4; i++) put($urandom_range(0, 7), i, 1'($urandom_range(0, 1)));
            1: begin sv[0] = 4'hF; sl[0] = 4'($urandom_range(0, 15)); end
            2: for (int i = 0; i < 4; i++)
                   if ($urandom_range(0, 1) == 1)
                       put($urandom_range(0, NK - 1), i, 1'($urandom_range(0, 1)));
            default: for (int k = 0; k < NK; k++)
                         for (int i = 0; i < 4; i++)
                             if ($urandom_range(0, 3) == 0) put(k, i, 1'($urandom_range(0, 1)));
        endcase
    endtask

    task automatic run_session(input logic cor, input int hold);
        exp_t e;
        for (int w = 0; w < 50 && busy; w++) begin @(posedge clk); #1; end
        chk("idle_before_start", 32'(busy), 32'd0);
        corrupt = cor;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        e = model(cor);
        e.e0 = cyc;
        sb.push_back(e);
        for (int k = 0; k < NK; k++) begin
            vote_valid = sv[k];
            vote_val   = sl[k];
            @(posedge clk); #1;
        end
        vote_valid = '0;
        chk("done_reached", 32'(result_valid), 32'd1);
        for (int h = 0; h < hold; h++) begin
            start = (h == 0);
            @(posedge clk); #1;
            start = 1'b0;
        end
        result_ack = 1'b1;
        @(posedge clk); #1;
        result_ack = 1'b0;
        corrupt = 1'b0;
        chk("released", 32'({busy, result_valid}), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) ack_cnt[i] = 0;
        #2;
        chk("reset_outputs", 32'({vote_ack, ballot, ballot_valid, result, result_valid,
                                   timed_out, verdict_err, busy}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Votes on separate edges: 1011 -> >=3 yes.
        clear_sched();
        put(0, 0, 1'b1); put(1, 1, 1'b1); put(2, 3, 1'b1); put(3, 2, 1'b0);
        run_session(1'b0, 0);
        // All four on one edge.
        clear_sched();
        sv[0] = 4'hF; sl[0] = 4'b0101;
        run_session(1'b0, 1);
        // Single voter, forced timeout.
        clear_sched();
        put(0, 0, 1'b1);
        run_session(1'b0, 0);
        // Repeat vote ignored.
        clear_sched();
        put(0, 2, 1'b1); put(2, 2, 1'b0);
        put(5, 0, 1'b0); put(5, 1, 1'b1); put(5, 3, 1'b0);
        run_session(1'b0, 0);
        // Fourth vote on the last timer edge closes normally.
        clear_sched();
        put(0, 0, 1'b1); put(0, 1, 1'b0); put(0, 2, 1'b1); put(TO - 1, 3, 1'b1);
        run_session(1'b0, 2);
        // Start pulsed in DONE plus corrupt verdict.
        clear_sched();
        sv[1] = 4'hF; sl[1] = 4'b1100;
        run_session(1'b1, 3);

        // Asynchronous reset in the middle of collection.
        clear_sched();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        vote_valid = 4'b0011; vote_val = 4'b0001;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midreset_outputs", 32'({vote_ack, ballot, ballot_valid, result, result_valid,
                                      timed_out, verdict_err, busy}), 32'd0);
        #1;
        vote_valid = '0;
        rst_n = 1'b1;

        for (int s = 0; s < 40; s++) begin
            gen_random($urandom_range(0, 3));
            run_session($urandom_range(0, 9) == 0, $urandom_range(0, 3));
        end

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
